// File: rtl/bsg_manycore_io_arbiter.sv
// rtl/bsg_manycore_io_arbiter.sv - round-robin I/O link arbiter with response demux; optional credits via BSG_MANYCORE_IO_ARB_CREDIT_EN
module bsg_manycore_io_arbiter #(
  parameter int num_in_p       = 4,
  parameter int width_p        = 37,
  parameter int x_cord_width_p = (num_in_p <= 1) ? 1 : $clog2(num_in_p),
  parameter int max_out_p      = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [num_in_p-1:0]         req_v_i,
  input  logic [num_in_p*width_p-1:0] req_data_i,
  output logic [num_in_p-1:0]         req_ready_o,
  output logic                        out_v_o,
  output logic [width_p-1:0]          out_data_o,
  output logic [x_cord_width_p-1:0]   out_src_o,
  input  logic                        out_ready_i,
  input  logic                        resp_v_i,
  input  logic [width_p-1:0]          resp_data_i,
  input  logic [x_cord_width_p-1:0]   resp_dest_i,
  output logic                        resp_ready_o,
  output logic [num_in_p-1:0]         resp_v_o,
  output logic [width_p-1:0]          resp_data_o,
  input  logic [num_in_p-1:0]         resp_ready_i,
  output logic                        err_o
);

  logic                      out_v_q;
  logic [width_p-1:0]        out_data_q;
  logic [x_cord_width_p-1:0] out_src_q;
  logic [x_cord_width_p-1:0] last_q;
  logic                      err_q;

  logic [num_in_p-1:0]       elig;
  logic [num_in_p-1:0]       grant;
  logic                      found;
  logic [x_cord_width_p-1:0] gidx;
  logic [width_p-1:0]        gdata;
  int                        sel_idx;
  logic                      slot_free;
  logic                      accept;
  logic                      dest_ok;
  logic                      resp_hs;
  logic                      underflow_err;

`ifdef BSG_MANYCORE_IO_ARB_CREDIT_EN
  localparam int cnt_w_lp = (max_out_p + 1 <= 1) ? 1 : $clog2(max_out_p + 1);
  localparam logic [cnt_w_lp-1:0] max_cnt_lp = cnt_w_lp'(max_out_p);

  logic [cnt_w_lp-1:0] cnt_q [num_in_p];
  logic [num_in_p-1:0] inc_v;
  logic [num_in_p-1:0] dec_v;
  logic [num_in_p-1:0] zero_v;

  assign inc_v = accept ? grant : '0;
  assign dec_v = resp_hs ? resp_v_o : '0;

  // Eligibility uses the registered count, so a same-cycle response cannot unblock a requester
  always_comb begin
    elig   = '0;
    zero_v = '0;
    for (int i = 0; i < num_in_p; i++) begin
      elig[i]   = req_v_i[i] && (cnt_q[i] < max_cnt_lp);
      zero_v[i] = (cnt_q[i] == '0);
    end
  end

  assign underflow_err = |(dec_v & zero_v);

  // Outstanding-request counters: +1 on accept, -1 on response; both together cancel; never below 0
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_in_p; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < num_in_p; i++) begin
        if (inc_v[i] && !dec_v[i])
          cnt_q[i] <= cnt_q[i] + cnt_w_lp'(1);
        else if (dec_v[i] && !inc_v[i] && !zero_v[i])
          cnt_q[i] <= cnt_q[i] - cnt_w_lp'(1);
      end
    end
  end
`else
  assign elig          = req_v_i;
  assign underflow_err = 1'b0;
`endif

  // Round-robin search starting just after the last accepted requester
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    gidx    = '0;
    gdata   = '0;
    sel_idx = 0;
    for (int k = 1; k <= num_in_p; k++) begin
      sel_idx = (int'(last_q) + k) % num_in_p;
      if (!found && elig[sel_idx]) begin
        found          = 1'b1;
        grant[sel_idx] = 1'b1;
        gidx           = x_cord_width_p'(sel_idx);
        gdata          = req_data_i[sel_idx*width_p +: width_p];
      end
    end
  end

  assign slot_free   = !out_v_q || out_ready_i;
  assign accept      = slot_free && found;
  assign req_ready_o = accept ? grant : '0;

  // Response demux by destination; out-of-range destinations are swallowed (ready=1, no valid)
  always_comb begin
    resp_v_o     = '0;
    dest_ok      = 1'b0;
    resp_ready_o = 1'b1;
    for (int i = 0; i < num_in_p; i++) begin
      if (int'(resp_dest_i) == i) begin
        dest_ok      = 1'b1;
        resp_v_o[i]  = resp_v_i;
        resp_ready_o = resp_ready_i[i];
      end
    end
  end

  assign resp_data_o = resp_data_i;
  assign resp_hs     = resp_v_i && resp_ready_o;

  // Output slot, round-robin pointer and sticky error flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
      last_q     <= x_cord_width_p'(num_in_p - 1);
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        out_v_q    <= 1'b1;
        out_data_q <= gdata;
        out_src_q  <= gidx;
        last_q     <= gidx;
      end else if (out_ready_i) begin
        out_v_q <= 1'b0;
      end
      if ((resp_hs && !dest_ok) || underflow_err)
        err_q <= 1'b1;
    end
  end

  assign out_v_o    = out_v_q;
  assign out_data_o = out_data_q;
  assign out_src_o  = out_src_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_bsg_manycore_io_arbiter.sv
// tb/tb_bsg_manycore_io_arbiter.sv - directed self-checking bench for bsg_manycore_io_arbiter
module tb_bsg_manycore_io_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int XW = 3;
  localparam int M  = 2;
`ifdef BSG_MANYCORE_IO_ARB_CREDIT_EN
  localparam bit CR = 1'b1;
`else
  localparam bit CR = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           reset_n_i;
  logic [N-1:0]   req_v_i;
  logic [N*W-1:0] req_data_i;
  logic [N-1:0]   req_ready_o;
  logic           out_v_o;
  logic [W-1:0]   out_data_o;
  logic [XW-1:0]  out_src_o;
  logic           out_ready_i;
  logic           resp_v_i;
  logic [W-1:0]   resp_data_i;
  logic [XW-1:0]  resp_dest_i;
  logic           resp_ready_o;
  logic [N-1:0]   resp_v_o;
  logic [W-1:0]   resp_data_o;
  logic [N-1:0]   resp_ready_i;
  logic           err_o;

  int checks = 0;
  int errors = 0;

  bsg_manycore_io_arbiter #(
    .num_in_p(N), .width_p(W), .x_cord_width_p(XW), .max_out_p(M)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .out_v_o(out_v_o), .out_data_o(out_data_o), .out_src_o(out_src_o), .out_ready_i(out_ready_i),
    .resp_v_i(resp_v_i), .resp_data_i(resp_data_i), .resp_dest_i(resp_dest_i), .resp_ready_o(resp_ready_o),
    .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_ready_i(resp_ready_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_data(input int i, input logic [W-1:0] d);
    req_data_i[i*W +: W] = d;
  endtask

  task automatic idle_inputs();
    req_v_i      = '0;
    out_ready_i  = 1'b1;
    resp_v_i     = 1'b0;
    resp_data_i  = '0;
    resp_dest_i  = '0;
    resp_ready_i = '0;
    for (int i = 0; i < N; i++) set_data(i, 16'h1000 + 16'(i));
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    #1;
  endtask

  initial begin
    reset_n_i = 1'b1;
    idle_inputs();
    #2 reset_n_i = 1'b0;
    #2;
    chk("rst_out_v", out_v_o, 0);
    chk("rst_out_data", out_data_o, 0);
    chk("rst_out_src", out_src_o, 0);
    chk("rst_err", err_o, 0);
    tick();
    reset_n_i = 1'b1;
    #1;
    chk("idle_ready", req_ready_o, 0);

    // round-robin rotation
    req_v_i = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), req_ready_o, 64'(1) << (k % 4));
      tick();
      chk($sformatf("rr_src%0d", k), out_src_o, k % 4);
      chk($sformatf("rr_data%0d", k), out_data_o, 16'h1000 + 16'(k % 4));
    end
    req_v_i = '0;
    tick();
    chk("rr_drain", out_v_o, 0);

    // backpressure
    do_reset();
    out_ready_i = 1'b0;
    req_v_i     = 4'b0001;
    set_data(0, 16'h00A5);
    #1;
    chk("bp_first_ready", req_ready_o, 4'b0001);
    tick();
    set_data(0, 16'h005A);
    chk("bp_loaded", out_data_o, 16'h00A5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_ready%0d", k), req_ready_o, 0);
      tick();
      chk($sformatf("bp_hold%0d", k), out_data_o, 16'h00A5);
      chk($sformatf("bp_v%0d", k), out_v_o, 1);
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_refill_ready", req_ready_o, 4'b0001);
    tick();
    chk("bp_refill_data", out_data_o, 16'h005A);
    chk("bp_refill_v", out_v_o, 1);
    req_v_i = '0;
    tick();
    chk("bp_empty", out_v_o, 0);

    // response pass-through and error cases
    do_reset();
    resp_v_i     = 1'b1;
    resp_dest_i  = 3'd2;
    resp_data_i  = 16'h1234;
    resp_ready_i = 4'b1011;
    #1;
    chk("resp_v_demux", resp_v_o, 4'b0100);
    chk("resp_ready_low", resp_ready_o, 0);
    chk("resp_data", resp_data_o, 16'h1234);
    resp_ready_i = 4'b0100;
    #1;
    chk("resp_ready_high", resp_ready_o, 1);
    tick();
    chk("resp_zero_cnt_err", err_o, CR);
    do_reset();
    resp_v_i     = 1'b1;
    resp_dest_i  = 3'd5;
    resp_ready_i = 4'b0000;
    #1;
    chk("oor_ready", resp_ready_o, 1);
    chk("oor_v", resp_v_o, 0);
    tick();
    chk("oor_err", err_o, 1);
    resp_v_i = 1'b0;
    tick();
    chk("oor_err_sticky", err_o, 1);

`ifdef BSG_MANYCORE_IO_ARB_CREDIT_EN
    // credit limit
    do_reset();
    req_v_i = 4'b0010;
    #1;
    chk("cr_acc1", req_ready_o, 4'b0010);
    tick();
    chk("cr_acc2", req_ready_o, 4'b0010);
    tick();
    chk("cr_block", req_ready_o, 0);
    tick();
    chk("cr_block_drain", out_v_o, 0);
    resp_v_i     = 1'b1;
    resp_dest_i  = 3'd1;
    resp_ready_i = 4'b0010;
    #1;
    chk("cr_same_cycle", req_ready_o, 0);
    tick();
    resp_v_i = 1'b0;
    #1;
    chk("cr_third", req_ready_o, 4'b0010);
    tick();
    chk("cr_third_src", out_src_o, 1);
    chk("cr_no_err", err_o, 0);

    // skip a blocked requester
    do_reset();
    req_v_i = 4'b0001;
    tick();
    tick();
    req_v_i = 4'b0101;
    #1;
    chk("skip_grant", req_ready_o, 4'b0100);
    tick();
    chk("skip_src", out_src_o, 2);
    req_v_i = 4'b1111;
    #1;
    chk("skip_last2", req_ready_o, 4'b1000);
    tick();
`endif

    // reset mid-operation
    do_reset();
    req_v_i = 4'b1000;
    tick();
    out_ready_i = 1'b0;
    tick();
    chk("mid_v_before", out_v_o, 1);
    req_v_i = '0;
    #2 reset_n_i = 1'b0;
    #1;
    chk("mid_v_async", out_v_o, 0);
    chk("mid_src_async", out_src_o, 0);
    tick();
    reset_n_i   = 1'b1;
    out_ready_i = 1'b1;
    req_v_i     = 4'b1111;
    #1;
    chk("mid_first_grant", req_ready_o, 4'b0001);
    tick();
    chk("mid_first_src", out_src_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
